// File: rtl/multi_clock_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multi_clock_divider
// Description : NUM_CH independent integer clock dividers driven from one
//               input clock. Each channel has a runtime-programmable divisor,
//               a registered divided clock and a one-cycle rising-edge tick.
//               A new divisor waits for the channel's period boundary, so
//               pulses are never shortened or stretched.
//               Optional macro MULTI_CLKDIV_SYNC_EN adds a sync_start input
//               that restarts all enabled channels in phase.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_clock_divider #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 6,
    localparam int C_CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [C_CH_W-1:0] cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
`ifdef MULTI_CLKDIV_SYNC_EN
    input  logic              sync_start,
`endif
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] div_tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    // All-ones counter value is never reached by a running count (max D-1 is
    // 2^DIV_W-2), so it doubles as the "terminal after reset/disable" state.
    localparam logic [DIV_W-1:0] c_CNT_TERM  = '1;
    localparam logic [DIV_W-1:0] c_RESET_DIV =
        (DEFAULT_DIV == 1) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

    logic             w_cfg_valid;
    logic [DIV_W-1:0] w_cfg_div;
    logic             w_force;

    // Out-of-range channel writes are dropped; a divisor of 1 is stored as 2.
    assign w_cfg_valid = cfg_we && (int'(cfg_ch) < NUM_CH);
    assign w_cfg_div   = (cfg_div == DIV_W'(1)) ? DIV_W'(2) : cfg_div;

`ifdef MULTI_CLKDIV_SYNC_EN
    assign w_force = sync_start;
`else
    assign w_force = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] r_act_q,  w_act_d;
        logic [DIV_W-1:0] r_pend_q, w_pend_d;
        logic [DIV_W-1:0] r_cnt_q,  w_cnt_d;
        logic             r_pend_v_q, w_pend_v_d;
        logic             r_clk_q,    w_clk_d;
        logic             r_tick_q,   w_tick_d;
        logic             w_wr;
        logic             w_term;
        logic [DIV_W-1:0] w_next_div;

        assign w_wr   = w_cfg_valid && (cfg_ch == C_CH_W'(i));
        assign w_term = (r_cnt_q == c_CNT_TERM) ||
                        (r_cnt_q == r_act_q - DIV_W'(1)) || w_force;

        // Next-state: disabled channels apply writes at once, running channels
        // defer them to the period boundary (or bypass when they coincide).
        always_comb begin
            w_act_d    = r_act_q;
            w_pend_d   = r_pend_q;
            w_pend_v_d = r_pend_v_q;
            w_cnt_d    = r_cnt_q;
            w_clk_d    = 1'b0;
            w_tick_d   = 1'b0;
            w_next_div = r_act_q;
            if (r_act_q == '0) begin
                w_cnt_d    = c_CNT_TERM;
                w_pend_v_d = 1'b0;
                if (w_wr) begin
                    w_act_d = w_cfg_div;
                end
            end else if (w_term) begin
                if (w_wr) begin
                    w_next_div = w_cfg_div;
                end else if (r_pend_v_q) begin
                    w_next_div = r_pend_q;
                end
                w_act_d    = w_next_div;
                w_pend_v_d = 1'b0;
                if (w_next_div == '0) begin
                    w_cnt_d = c_CNT_TERM;
                end else begin
                    w_cnt_d  = '0;
                    w_clk_d  = 1'b1;
                    w_tick_d = 1'b1;
                end
            end else begin
                w_cnt_d = r_cnt_q + DIV_W'(1);
                // High phase is the first D-floor(D/2) counts of the period.
                w_clk_d = (w_cnt_d < (r_act_q - (r_act_q >> 1)));
                if (w_wr) begin
                    w_pend_d   = w_cfg_div;
                    w_pend_v_d = 1'b1;
                end
            end
        end

        // Channel state registers with synchronous reset to the terminal state.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_act_q    <= c_RESET_DIV;
                r_pend_q   <= '0;
                r_pend_v_q <= 1'b0;
                r_cnt_q    <= c_CNT_TERM;
                r_clk_q    <= 1'b0;
                r_tick_q   <= 1'b0;
            end else begin
                r_act_q    <= w_act_d;
                r_pend_q   <= w_pend_d;
                r_pend_v_q <= w_pend_v_d;
                r_cnt_q    <= w_cnt_d;
                r_clk_q    <= w_clk_d;
                r_tick_q   <= w_tick_d;
            end
        end

        assign div_clk[i]     = r_clk_q;
        assign div_tick[i]    = r_tick_q;
        assign cfg_pending[i] = r_pend_v_q;
    end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_multi_clock_divider
// Description : Directed plus random stimulus for multi_clock_divider, checked
//               against a period-timestamp reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_clock_divider;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 6;
    localparam int CH_W        = 2;
`ifdef MULTI_CLKDIV_SYNC_EN
    localparam bit HAS_SYNC = 1'b1;
`else
    localparam bit HAS_SYNC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              sync_start;
    logic [NUM_CH-1:0] div_clk;
    logic [NUM_CH-1:0] div_tick;
    logic [NUM_CH-1:0] cfg_pending;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    // Reference model: each channel is described by its active divisor and the
    // edge number on which the current period started.
    int                m_act   [NUM_CH];
    int                m_pend  [NUM_CH];
    bit                m_pv    [NUM_CH];
    int                m_start [NUM_CH];
    logic [NUM_CH-1:0] m_clk;
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_pvec;

    always #5 clk = ~clk;

    multi_clock_divider #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
`ifdef MULTI_CLKDIV_SYNC_EN
        .sync_start  (sync_start),
`endif
        .div_clk     (div_clk),
        .div_tick    (div_tick),
        .cfg_pending (cfg_pending)
    );

    task automatic model_edge();
        int dv;
        int newd;
        bit wr;
        bit bnd;
        dv = (int'(cfg_div) == 1) ? 2 : int'(cfg_div);
        for (int i = 0; i < NUM_CH; i++) begin
            wr = cfg_we && (int'(cfg_ch) == i);
            if (reset) begin
                m_act[i]   = DEFAULT_DIV;
                m_pv[i]    = 1'b0;
                m_start[i] = edge_n + 1 - DEFAULT_DIV;
                m_clk[i]   = 1'b0;
                m_tick[i]  = 1'b0;
            end else if (m_act[i] == 0) begin
                m_clk[i]  = 1'b0;
                m_tick[i] = 1'b0;
                if (wr && dv != 0) begin
                    m_act[i]   = dv;
                    m_start[i] = edge_n + 1 - dv;
                end
            end else begin
                bnd = (edge_n == m_start[i] + m_act[i]) || (HAS_SYNC && sync_start);
                if (bnd) begin
                    newd       = wr ? dv : (m_pv[i] ? m_pend[i] : m_act[i]);
                    m_pv[i]    = 1'b0;
                    m_act[i]   = newd;
                    m_start[i] = edge_n;
                    m_tick[i]  = (newd != 0);
                    m_clk[i]   = (newd != 0);
                end else begin
                    m_tick[i] = 1'b0;
                    m_clk[i]  = ((edge_n - m_start[i]) < (m_act[i] - m_act[i] / 2));
                    if (wr) begin
                        m_pend[i] = dv;
                        m_pv[i]   = 1'b1;
                    end
                end
            end
            m_pvec[i] = m_pv[i];
        end
    endtask

    task automatic check(input string tag, input logic [NUM_CH-1:0] got,
                         input logic [NUM_CH-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, edge_n, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit we, input int ch, input int dv,
                        input bit sy);
        reset      = rst;
        cfg_we     = we;
        cfg_ch     = CH_W'(ch);
        cfg_div    = DIV_W'(dv);
        sync_start = sy;
        @(posedge clk);
        model_edge();
        #1;
        check("div_clk",     div_clk,     m_clk);
        check("div_tick",    div_tick,    m_tick);
        check("cfg_pending", cfg_pending, m_pvec);
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int r_ch;
        int r_dv;
        // Reset, then release: ticks on the first edge and every 6 after.
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        check("reset_clk", div_clk, '0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        check("release_tick", div_tick, '1);
        idle(13);

        // ch0 <- 3 mid-period, deferred to the boundary.
        idle(2);
        step(1'b0, 1'b1, 0, 3, 1'b0);
        idle(12);

        // ch1 <- 0, then ch1 <- 4 once stopped.
        step(1'b0, 1'b1, 1, 0, 1'b0);
        idle(10);
        step(1'b0, 1'b1, 1, 4, 1'b0);
        idle(10);

        // Double write to ch0 (last wins) and an out-of-range write.
        step(1'b0, 1'b1, 0, 5, 1'b0);
        step(1'b0, 1'b1, 0, 7, 1'b0);
        step(1'b0, 1'b1, 3, 2, 1'b0);
        idle(20);

        // ch0 <- 9, reset during its high phase.
        step(1'b0, 1'b1, 0, 9, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        idle(14);

        // ch0 <- 4, ch1 <- 6, ch2 <- 1 (stored as 2), then a sync pulse.
        step(1'b0, 1'b1, 0, 4, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1, 6, 1'b0);
        step(1'b0, 1'b1, 2, 1, 1'b0);
        idle(9);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        idle(30);

        // Randomized traffic.
        for (int k = 0; k < 900; k++) begin
            r_ch = $urandom_range(0, 3);
            r_dv = ($urandom_range(0, 30) == 0) ? $urandom_range(0, 255)
                                                : $urandom_range(0, 9);
            step(($urandom_range(0, 120) == 0), ($urandom_range(0, 5) == 0),
                 r_ch, r_dv, ($urandom_range(0, 50) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Parametrised successor to the fixed two-output clock divider.
- NUM_CH independent divided-clock channels are generated from one input clock. Each channel has its own runtime-programmable integer divisor.
- Each channel outputs a registered divided clock and a one-cycle rising-edge strobe.
- Sits between the system clock and the write/read domain logic. Lets the FIFO test setup sweep write/read clock ratios without re-synthesis.

Parameters:
- NUM_CH, 2, number of output channels (1..16).
- DIV_W, 8, divisor width in bits; maximum divisor is 2^DIV_W-1.
- DEFAULT_DIV, 6, divisor loaded into every channel at reset (must be 0 or >=2).

Ports:
- clk  input  1  input clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_we  input  1  configuration write strobe, sampled each cycle.
- cfg_ch  input  $clog2(NUM_CH) (min 1)  channel index for the write.
- cfg_div  input  DIV_W  new divisor; 0 = disable channel, 1 = treated as 2.
- div_clk  output  NUM_CH  divided clock per channel, registered.
- div_tick  output  NUM_CH  one-cycle strobe, high in the cycle div_clk[i] goes 0->1.
- cfg_pending  output  NUM_CH  high while a written divisor is waiting for its period boundary.

Behaviour:
- Reset (any cycle, including mid-period):
  - Active divisor of every channel = DEFAULT_DIV.
  - Pending register cleared, cfg_pending=0.
  - div_clk=0, div_tick=0.
  - Counter forced to the terminal state.
- Per channel with active divisor D>=2:
  - H = D - (D>>1) high cycles, L = D>>1 low cycles; period exactly D clk cycles.
  - Odd D gives the high phase one extra cycle: D=3 -> 2 high/1 low; D=5 -> 3/2.
- Counter cnt runs 0..D-1:
  - At terminal (cnt==D-1, or the reset terminal state) the next edge loads 0; otherwise cnt+1.
  - div_clk <= (next cnt < H).
  - div_tick <= (next cnt == 0).
- First active edge after reset release starts a period: div_clk=1 and div_tick=1 on that edge.
- Period boundary is the edge where cnt wraps to 0.
- cfg write with cfg_ch < NUM_CH:
  - cfg_div is captured into that channel's pending register; cfg_pending[ch]=1 from the next cycle.
  - The pending value becomes the active divisor at the next period boundary; cfg_pending clears on that edge.
  - Result: no shortened or stretched pulse on div_clk.
- Write in the same cycle as a boundary: bypass; the new value governs the period starting at that edge; cfg_pending stays 0.
- Second write before the first is applied: overwrites the pending value; only the last one is applied.
- cfg_ch >= NUM_CH: write ignored, no state change.
- cfg_div=1: stored as 2.
- Disabled channel (active D=0):
  - div_clk=0, div_tick=0, counter held at terminal.
  - A write of a nonzero value is applied on the next edge without waiting for a boundary. The new period starts on the edge after that: div_tick=1 two cycles after cfg_we.
- Writing 0 to a running channel: takes effect at the next boundary; from that edge div_clk stays 0 and no tick is issued.
- Channels are fully independent; simultaneous boundaries on several channels do not interact.
- Only one cfg write per cycle.

Optional Feature:
- Macro: MULTI_CLKDIV_SYNC_EN.
- When defined:
  - Adds input port sync_start (1 bit), placed after cfg_div.
  - sync_start=1 forces every enabled channel to terminal, so all enabled channels tick together on the following edge.
  - Pending divisors are applied at this forced boundary.
  - Disabled channels are unaffected.
  - reset has priority over sync_start.
- When undefined: the port does not exist and phases are set only by reset and individual programming.

Test Plan:
- Reset release, NUM_CH=2, DEFAULT_DIV=6 -> both div_clk 1,1,1,0,0,0 repeating; div_tick at cycles 1,7,13.
- Write ch0=3 mid-period (cnt=2) -> old period completes 6 cycles; then 2 high/1 low; cfg_pending[0] high until the boundary.
- Write ch1=0, then ch1=4 four cycles after ch1 stops -> ch1 low after boundary; div_tick[1] exactly 2 cycles after the second write; then 2/2 pattern.
- Two writes to ch0 (5 then 7) within one period; also cfg_ch=3 with NUM_CH=2 -> only 7 applied; invalid write causes no change anywhere.
- Assert reset for one cycle while ch0 (D=9) is in its high phase -> outputs 0 the next edge; the edge after release ticks; divisor back to 6.
- With MULTI_CLKDIV_SYNC_EN, ch0=4, ch1=6 out of phase, pulse sync_start -> both div_tick high on the following edge; ticks coincide again every 12 cycles.
